// File: rtl/run_ctl_pkg.sv
// Shared types and counter-width helpers for the run/reset sequencer.
package run_ctl_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_HOLD = 2'd1,
        S_ARM  = 2'd2,
        S_RUN  = 2'd3
    } run_state_e;

    // Bits needed to hold 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count == 0) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int unsigned hold_cnt_width(input int unsigned hold_cycles,
                                                   input int unsigned arm_cycles);
        return cnt_width((hold_cycles > arm_cycles) ? hold_cycles : arm_cycles);
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer for one switch.
module switch_debouncer
    import run_ctl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;

    // A differing sample must persist for DEBOUNCE_CYCLES cycles before it is taken.
    always_comb begin
        level_nxt = level;
        cnt_nxt   = '0;
        if (sync_q2 != level) begin
            if (cnt_q >= CNT_LAST) begin
                level_nxt = sync_q2;
            end else begin
                cnt_nxt = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            cnt_q   <= cnt_nxt;
            level   <= level_nxt;
        end
    end

endmodule

// File: rtl/run_reset_sequencer.sv
// Conditions the front-panel switches and sequences 68000 /RESET and /HALT
// so the CPU sees a full reset-hold period before it is released to run.
module run_reset_sequencer
    import run_ctl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 200000,
    parameter int unsigned RESET_HOLD_CYCLES = 2000000,
    parameter int unsigned ARM_CYCLES        = 16
) (
    input  logic MCLK_IN,
    input  logic RESET_IN,
    input  logic RUN_SW_IN,
    input  logic STEP_SW_IN,
    input  logic STEPEN_SW_IN,
    output logic RUN,
    output logic STEP,
    output logic STEPEN,
    output logic CPU_RESET,
    output logic CPU_HALT
);

    localparam int unsigned HW = hold_cnt_width(RESET_HOLD_CYCLES, ARM_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
    localparam logic [HW-1:0] ARM_LAST  = HW'(ARM_CYCLES - 1);

    logic          run_db;
    run_state_e    state_q;
    run_state_e    state_nxt;
    logic [HW-1:0] cnt_q;
    logic [HW-1:0] cnt_nxt;
    logic          run_nxt;
    logic          cpu_reset_nxt;

    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk   (MCLK_IN),
        .rst   (RESET_IN),
        .raw   (RUN_SW_IN),
        .level (run_db)
    );

    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk   (MCLK_IN),
        .rst   (RESET_IN),
        .raw   (STEP_SW_IN),
        .level (STEP)
    );

    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stepen_db (
        .clk   (MCLK_IN),
        .rst   (RESET_IN),
        .raw   (STEPEN_SW_IN),
        .level (STEPEN)
    );

    // Next state and counter; dropping RUN aborts from any active state.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = '0;
        unique case (state_q)
            S_OFF: begin
                if (run_db) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!run_db) begin
                    state_nxt = S_OFF;
                end else if (cnt_q >= HOLD_LAST) begin
                    state_nxt = S_ARM;
                end else begin
                    cnt_nxt = cnt_q + HW'(1);
                end
            end
            S_ARM: begin
                if (!run_db) begin
                    state_nxt = S_OFF;
                end else if (cnt_q >= ARM_LAST) begin
                    state_nxt = S_RUN;
                end else begin
                    cnt_nxt = cnt_q + HW'(1);
                end
            end
            S_RUN: begin
                if (!run_db) state_nxt = S_OFF;
            end
            default: state_nxt = S_OFF;
        endcase
    end

    // Outputs are decoded from the next state so they land with the state change.
    always_comb begin
        run_nxt       = 1'b0;
        cpu_reset_nxt = 1'b1;
        if (state_nxt == S_ARM || state_nxt == S_RUN) run_nxt = 1'b1;
        if (state_nxt == S_RUN) cpu_reset_nxt = 1'b0;
    end

    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            RUN       <= 1'b0;
            CPU_RESET <= 1'b1;
            CPU_HALT  <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            RUN       <= run_nxt;
            CPU_RESET <= cpu_reset_nxt;
            CPU_HALT  <= cpu_reset_nxt;
        end
    end

endmodule

// File: tb/tb_run_reset_sequencer.sv
// Directed bench for run_reset_sequencer with short debounce/hold/arm periods.
module tb_run_reset_sequencer;

    logic clk;
    logic reset_in;
    logic run_sw;
    logic step_sw;
    logic stepen_sw;
    logic run;
    logic step;
    logic stepen;
    logic cpu_reset;
    logic cpu_halt;

    int n_checks = 0;
    int n_fail   = 0;

    run_reset_sequencer #(
        .DEBOUNCE_CYCLES   (4),
        .RESET_HOLD_CYCLES (10),
        .ARM_CYCLES        (2)
    ) dut (
        .MCLK_IN      (clk),
        .RESET_IN     (reset_in),
        .RUN_SW_IN    (run_sw),
        .STEP_SW_IN   (step_sw),
        .STEPEN_SW_IN (stepen_sw),
        .RUN          (run),
        .STEP         (step),
        .STEPEN       (stepen),
        .CPU_RESET    (cpu_reset),
        .CPU_HALT     (cpu_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, ending on a falling edge.
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected vector order: {RUN, STEP, STEPEN, CPU_RESET, CPU_HALT}.
    task automatic chk(input string tag, input int k, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {run, step, stepen, cpu_reset, cpu_halt};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d: observed %b expected %b (RUN STEP STEPEN CPU_RESET CPU_HALT)",
                   tag, k, obs, exp);
        end
    endtask

    initial begin
        reset_in  = 1'b1;
        run_sw    = 1'b1;
        step_sw   = 1'b1;
        stepen_sw = 1'b1;

        // Reset with every switch closed.
        edges(1);
        chk("reset_e1", 1, 5'b00011);
        edges(1);
        chk("reset_e2", 2, 5'b00011);
        reset_in = 1'b0;
        edges(5);
        chk("post_reset_e5", 5, 5'b00011);
        edges(1);
        chk("post_reset_e6", 6, 5'b01111);

        // Drop RUN and STEP right after run debounces: abort mid-hold, RUN never rises.
        run_sw  = 1'b0;
        step_sw = 1'b0;
        for (int k = 7; k <= 30; k++) begin
            edges(1);
            chk("hold_abort", k, {1'b0, (k < 12), 1'b1, 1'b1, 1'b1});
        end

        // Clean RUN press from S_OFF: RUN at edge 17, CPU released at edge 19.
        run_sw = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            edges(1);
            chk("run_press", k, {(k >= 17), 1'b0, 1'b1, (k < 19), (k < 19)});
        end

        // STEP bounces every 2 cycles; debounced level must stay low.
        for (int j = 0; j < 20; j++) begin
            step_sw = ((j / 2) % 2 == 0);
            edges(1);
            chk("step_bounce", j, 5'b10100);
        end
        step_sw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            edges(1);
            chk("step_settle", k, {1'b1, (k >= 6), 1'b1, 1'b0, 1'b0});
        end

        // RUN released while running: S_OFF outputs exactly 7 edges later.
        run_sw = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            edges(1);
            chk("run_release", k, {(k < 7), 1'b1, 1'b1, (k >= 7), (k >= 7)});
        end

        // Back to S_RUN, then a one-cycle reset with all switches closed.
        run_sw = 1'b1;
        edges(19);
        chk("rerun_e19", 19, 5'b11100);
        reset_in = 1'b1;
        edges(1);
        chk("reset_in_run", 0, 5'b00011);
        reset_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            edges(1);
            chk("reseq", k, {(k >= 17), (k >= 6), (k >= 6), (k < 19), (k < 19)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_reset_sequencer.md
Name: run_reset_sequencer

Overview:
- Upstream of the 68000 bus controller; conditions the front-panel RUN, STEP and STEPEN switches.
- Produces the clean RUN, STEP and STEPEN levels that the bus controller consumes.
- Sequences the 68000 /RESET and /HALT lines so the CPU sees a full reset-hold period before RUN releases it.
- Ensures the bus controller's bootstrap and stepper state is always cleared in step with a CPU reset.

Parameters:
- DEBOUNCE_CYCLES, 200000: consecutive stable MCLK cycles required before a switch level is accepted; must be ≥1.
- RESET_HOLD_CYCLES, 2000000: MCLK cycles that CPU_RESET and CPU_HALT stay asserted after RUN is requested; default gives 100 ms at 20 MHz. Must be ≥1.
- ARM_CYCLES, 16: cycles with RUN=1 while the CPU is still held in reset, letting the bus controller leave its reset first; must be ≥1.

Ports:
- MCLK_IN  input  1  system clock; all logic on the rising edge.
- RESET_IN  input  1  synchronous, active-high reset.
- RUN_SW_IN  input  1  raw RUN switch, asynchronous, bouncy; 1 = run requested.
- STEP_SW_IN  input  1  raw STEP push-button, asynchronous, bouncy; 1 = pressed.
- STEPEN_SW_IN  input  1  raw step-mode switch, asynchronous, bouncy; 1 = step mode.
- RUN  output  1  to the bus controller's RUN_IN; 1 = bus controller active.
- STEP  output  1  debounced STEP level, to the bus controller's STEP_IN.
- STEPEN  output  1  debounced STEPEN level, to the bus controller's STEPEN_IN.
- CPU_RESET  output  1  1 = drive 68000 /RESET low (via external open-drain buffer).
- CPU_HALT  output  1  1 = drive 68000 /HALT low (via external open-drain buffer).

Behaviour:
- Reset: RESET_IN=1 at a rising edge forces the following values. Reset wins over every other event in the same cycle.
  - Outputs: RUN=0, STEP=0, STEPEN=0, CPU_RESET=1, CPU_HALT=1.
  - Internal: synchronisers and debounced levels = 0, all counters = 0, FSM = S_OFF.
- Synchroniser: each raw switch passes through 2 flops; no logic reads a raw input directly.
- Debouncer (per switch):
  - Holds a debounced level D and a stable counter C.
  - Synchronised value == D: C cleared.
  - Otherwise C increments; when C reaches DEBOUNCE_CYCLES−1 and the value still differs, D takes the new value and C clears.
  - Any reversal before that point clears C, and D is unchanged.
  - Latency: a clean raw edge changes D at exactly 2+DEBOUNCE_CYCLES edges after the first edge that samples it. D never glitches.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); C saturates and never wraps.
- STEP and STEPEN are the registered debounced levels, passed through in any FSM state.
- FSM, all outputs registered:
  - S_OFF: RUN=0, CPU_RESET=1, CPU_HALT=1. Debounced run=1 → S_HOLD, hold counter cleared.
  - S_HOLD: RUN=0, CPU_RESET=1, CPU_HALT=1. Counter increments every cycle; at RESET_HOLD_CYCLES−1 → S_ARM, counter cleared.
  - S_ARM: RUN=1, CPU_RESET=1, CPU_HALT=1 for ARM_CYCLES cycles, then → S_RUN.
  - S_RUN: RUN=1, CPU_RESET=0, CPU_HALT=0. Stays until debounced run=0.
  - From S_HOLD, S_ARM or S_RUN: debounced run=0 → S_OFF at the next edge, so outputs take their S_OFF values 1 cycle after D falls. Counter cleared.
  - A re-press always runs a full debounce plus the full RESET_HOLD_CYCLES; there is no partial-hold resume.
- Output invariants:
  - CPU_RESET and CPU_HALT always equal each other.
  - RUN=0 implies CPU_RESET=1. CPU_RESET=0 implies RUN=1.
  - Hold counter width is $clog2(max(RESET_HOLD_CYCLES, ARM_CYCLES)+1).

Decomposition:
- Shared package run_ctl_pkg holds:
  - state typedef {S_OFF, S_HOLD, S_ARM, S_RUN}, 2-bit, binary-encoded;
  - the counter-width localparam functions.
- Sub-module switch_debouncer (2-flop synchroniser + stable counter, parameter DEBOUNCE_CYCLES), instantiated 3 times.
- The top level holds the FSM and hold counter.

Test Plan (DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=10, ARM_CYCLES=2):
1. RESET_IN=1 for 2 cycles with all switches =1 → RUN=0, STEP=0, STEPEN=0, CPU_RESET=1, CPU_HALT=1; after release, STEPEN=1 exactly 6 edges later.
2. RUN_SW_IN clean 0→1 → debounced run at edge 6, S_HOLD at 7, RUN=1 at edge 17, CPU_RESET=CPU_HALT=0 at edge 19.
3. STEP_SW_IN toggles every 2 cycles for 20 cycles, then holds 1 → STEP stays 0 throughout the bounce and rises exactly 6 edges after the final transition, with no glitch.
4. RUN_SW_IN drops to 0 at hold count 5 → FSM to S_OFF, RUN never asserts; re-press gives RUN=1 after a full 4+2+1+10 edges.
5. RUN_SW_IN 1→0 while in S_RUN → RUN=0, CPU_RESET=1, CPU_HALT=1 exactly 7 edges after the raw edge (6 debounce + 1 FSM).
6. RESET_IN pulsed for 1 cycle in S_RUN with RUN_SW_IN held 1 → reset values at the next edge, then full re-sequence; RUN=1 again 17 edges after reset release.
